// File: rtl/fafs_pkg.sv
// -----------------------------------------------------------------------------
// fafs_pkg
// Shared definitions for the bit-serial adder/subtractor and its 1-bit cell.
//   state_e  : sequencer states (IDLE / RUN / DONE)
//   MODE_ADD : mode value selecting A+B+CIN
//   MODE_SUB : mode value selecting A-B-CIN
// -----------------------------------------------------------------------------
package fafs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : fafs_pkg

// File: rtl/fafs_bit.sv
// -----------------------------------------------------------------------------
// fafs_bit
// Purely combinational 1-bit full adder / full subtractor cell.
// Ports:
//   a, b  : operand bits
//   c     : carry in (add) or borrow in (subtract)
//   mode  : MODE_ADD or MODE_SUB
//   r     : sum or difference bit
//   cout  : carry out (add) or borrow out (subtract)
// -----------------------------------------------------------------------------
module fafs_bit
  import fafs_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic r,
  output logic cout
);

  // Sum and difference bits are the same three-input parity.
  assign r = a ^ b ^ c;

  always_comb begin
    cout = (a & b) | (c & (a ^ b));
    if (mode == MODE_SUB) begin
      cout = (~a & b) | (c & ~(a ^ b));
    end
  end

endmodule : fafs_bit

// File: rtl/serial_fafs.sv
// -----------------------------------------------------------------------------
// serial_fafs
// Bit-serial adder/subtractor. Two WIDTH-bit operands are processed LSB first,
// one bit per clock, through a single shared fafs_bit cell.
// Ports:
//   CLK    : clock, all state changes on the rising edge
//   RST    : synchronous active-high reset, overrides every other input
//   START  : operation request, only looked at while BUSY=0
//   MODE   : 0 = A+B+CIN, 1 = A-B-CIN
//   A, B   : operands, latched on the accepting edge
//   CIN    : initial carry/borrow, latched with the operands
//   BUSY   : high while bits are being processed
//   DONE   : one-cycle pulse, RESULT/CO/OV valid from this cycle
//   RESULT : sum or difference
//   CO     : final carry (add) or final borrow (subtract)
//   OV     : two's-complement signed overflow
//
// Handshake: a request is accepted on any rising edge where START=1 and
// BUSY=0 (IDLE or DONE). The operation then runs for exactly WIDTH cycles
// with BUSY=1, ignoring START and input changes, and DONE pulses for one
// cycle in the cycle that begins WIDTH edges after the accepting edge.
// RESULT/CO/OV hold from DONE until the next accepting edge.
// -----------------------------------------------------------------------------
module serial_fafs
  import fafs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CO,
  output logic             OV
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             mode_q,  mode_d;
  logic             c_q,     c_d;
  logic             co_q,    co_d;
  logic             ov_q,    ov_d;

  logic cell_r;
  logic cell_cout;

  // Operand registers shift right, so bit 0 is always the bit being processed.
  fafs_bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (c_q),
    .mode (mode_q),
    .r    (cell_r),
    .cout (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    mode_d  = mode_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (START) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = A;
          b_d     = B;
          mode_d  = MODE;
          c_d     = CIN;
          res_d   = '0;
          co_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = cell_cout;
        cnt_d = cnt_q + CW'(1);
        // Result enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = cell_r;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          co_d    = cell_cout;
          // Carry into the MSB differs from carry out of it => signed overflow.
          ov_d    = c_q ^ cell_cout;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign BUSY   = (state_q == S_RUN);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = res_q;
  assign CO     = co_q;
  assign OV     = ov_q;

endmodule : serial_fafs

// File: tb/tb_serial_fafs.sv
// -----------------------------------------------------------------------------
// tb_serial_fafs
// Bench for serial_fafs at WIDTH=1 and WIDTH=8. An arithmetic reference model
// predicts BUSY/DONE timing and the RESULT/CO/OV values; a per-cycle compare
// process checks each DUT against its model, and directed tests pin literal
// values from hand calculation.
// -----------------------------------------------------------------------------
module tb_serial_fafs;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH=1 instance signals
  logic start1 = 1'b0, mode1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic busy1, done1, co1, ov1;
  logic [0:0] res1;

  // WIDTH=8 instance signals
  logic       start8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8, ov8;
  logic [7:0] res8;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  serial_fafs #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .MODE(mode1), .A(a1), .B(b1),
    .CIN(cin1), .BUSY(busy1), .DONE(done1), .RESULT(res1), .CO(co1), .OV(ov1)
  );

  serial_fafs #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .START(start8), .MODE(mode8), .A(a8), .B(b8),
    .CIN(cin8), .BUSY(busy8), .DONE(done8), .RESULT(res8), .CO(co8), .OV(ov8)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-integer reference: returns {ov, co, result[31:0]}.
  function automatic logic [33:0] ref_op(input int w, input logic m,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    longint ua, ub, full, mask;
    logic [31:0] res;
    logic co, ov, sa, sb, sr;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (m == 1'b0) begin
      full = ua + ub + longint'(c);
      co   = ((full >> w) & 1) != 0;
    end else begin
      full = ua - ub - longint'(c);
      co   = (ua < ub + longint'(c));
    end
    res = 32'(full & mask);
    sa  = a[w-1];
    sb  = b[w-1];
    sr  = res[w-1];
    if (m == 1'b0) ov = (sa == sb) && (sr != sa);
    else           ov = (sa != sb) && (sr != sa);
    return {ov, co, res};
  endfunction

  // ---------------- behavioural models ----------------
  // cnt = cycles of processing still owed; an operation accepted on an edge
  // completes WIDTH edges later, and its values then hold until reset.
  int          m1_cnt = 0, m8_cnt = 0;
  logic        m1_done = 1'b0, m8_done = 1'b0;
  logic [33:0] m1_out = '0, m8_out = '0, m1_pend = '0, m8_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m1_cnt = 0; m1_done = 1'b0; m1_out = '0;
    end else if (m1_cnt > 0) begin
      m1_cnt--;
      if (m1_cnt == 0) begin m1_done = 1'b1; m1_out = m1_pend; end
    end else begin
      m1_done = 1'b0;
      if (start1) begin
        m1_pend = ref_op(1, mode1, {31'b0, a1}, {31'b0, b1}, cin1);
        m1_cnt  = 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m8_cnt = 0; m8_done = 1'b0; m8_out = '0;
    end else if (m8_cnt > 0) begin
      m8_cnt--;
      if (m8_cnt == 0) begin m8_done = 1'b1; m8_out = m8_pend; end
    end else begin
      m8_done = 1'b0;
      if (start8) begin
        m8_pend = ref_op(8, mode8, {24'b0, a8}, {24'b0, b8}, cin8);
        m8_cnt  = 8;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy1", busy1, m1_cnt > 0);
      chk("done1", done1, m1_done);
      if (m1_cnt == 0) begin
        chk("result1", res1, m1_out[0]);
        chk("co1", co1, m1_out[32]);
        chk("ov1", ov1, m1_out[33]);
      end
      chk("busy8", busy8, m8_cnt > 0);
      chk("done8", done8, m8_done);
      if (m8_cnt == 0) begin
        chk("result8", res8, m8_out[7:0]);
        chk("co8", co8, m8_out[32]);
        chk("ov8", ov8, m8_out[33]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b,
                     input logic c, output int lat);
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0;
    // Operand changes during the run must have no effect.
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
    end
  endtask

  task automatic op1(input logic m, input logic a, input logic b,
                     input logic c, output int lat);
    @(negedge clk);
    start1 = 1'b1; mode1 = m; a1 = a; b1 = b; cin1 = c;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); mode1 = 1'($urandom); cin1 = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done1) begin lat = k; break; end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n_done;
    logic [3:0] v;

    // Model pins against hand-computed values
    chk("ref_add_7f", ref_op(8, 1'b0, 32'h7F, 32'h01, 1'b0), {1'b1, 1'b0, 32'h80});
    chk("ref_add_ff", ref_op(8, 1'b0, 32'hFF, 32'h01, 1'b1), {1'b0, 1'b1, 32'h01});
    chk("ref_sub_00", ref_op(8, 1'b1, 32'h00, 32'h01, 1'b0), {1'b0, 1'b1, 32'hFF});
    chk("ref_sub_80", ref_op(8, 1'b1, 32'h80, 32'h01, 1'b0), {1'b1, 1'b0, 32'h7F});
    chk("ref_w1_sub", ref_op(1, 1'b1, 32'h0, 32'h1, 1'b1), {1'b0, 1'b1, 32'h0});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_res8", res8, 8'h00);
    chk("rst_co8", co8, 1'b0);
    chk("rst_ov8", ov8, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk_en = 1'b1;

    // WIDTH=1: all 16 {MODE,A,B,CIN} combinations
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      op1(v[3], v[2], v[1], v[0], lat);
      chk("lat_w1", lat, 1);
      chk("ov_w1_cin_xor_co", ov1, v[0] ^ co1);
      if (i == 7)  begin chk("w1_add111_r", res1, 1'b1); chk("w1_add111_co", co1, 1'b1); end
      if (i == 9)  begin chk("w1_sub001_r", res1, 1'b1); chk("w1_sub001_bo", co1, 1'b1); end
      if (i == 12) begin chk("w1_sub100_r", res1, 1'b1); chk("w1_sub100_bo", co1, 1'b0); end
    end

    // WIDTH=8 directed boundary cases
    op8(1'b0, 8'h7F, 8'h01, 1'b0, lat);
    chk("lat_add_7f", lat, 8);
    chk("res_add_7f", res8, 8'h80); chk("co_add_7f", co8, 1'b0); chk("ov_add_7f", ov8, 1'b1);

    op8(1'b0, 8'hFF, 8'h01, 1'b1, lat);
    chk("lat_add_ff", lat, 8);
    chk("res_add_ff", res8, 8'h01); chk("co_add_ff", co8, 1'b1); chk("ov_add_ff", ov8, 1'b0);

    op8(1'b1, 8'h00, 8'h01, 1'b0, lat);
    chk("res_sub_00", res8, 8'hFF); chk("co_sub_00", co8, 1'b1); chk("ov_sub_00", ov8, 1'b0);

    op8(1'b1, 8'h80, 8'h01, 1'b0, lat);
    chk("res_sub_80", res8, 8'h7F); chk("co_sub_80", co8, 1'b0); chk("ov_sub_80", ov8, 1'b1);

    // START pulsed at RUN cycles 3 and 5 must be ignored
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0;
    @(posedge clk); #1 start8 = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done8) n_done++;
      start8 = (k == 3 || k == 5);
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    end
    start8 = 1'b0;
    chk("ignored_start_dones", n_done, 1);
    chk("ignored_start_res", res8, 8'h7F);

    // START held high: one accept per DONE cycle, one DONE every 9 cycles
    @(negedge clk);
    start8 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    n_done = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done8) n_done++;
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    end
    start8 = 1'b0;
    chk("held_start_dones", n_done, 5);
    repeat (12) @(posedge clk);

    // Reset in RUN cycle 4 aborts the operation
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_res", res8, 8'h00);
    chk("abort_co", co8, 1'b0);
    chk("abort_ov", ov8, 1'b0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    op8(1'b0, 8'h12, 8'h34, 1'b0, lat);
    chk("after_abort_lat", lat, 8);
    chk("after_abort_res", res8, 8'h46);

    // Randomized operations with random idle gaps
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), lat);
      chk("rand_lat", lat, 8);
    end
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), lat);
      chk("rand_lat_w1", lat, 1);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_fafs
